// File: rtl/midisynth_pkg.sv
// Shared constants for the MIDI synth SPI path: frame geometry, command codes, FSM encoding.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package midisynth_pkg;

    localparam int          FRAME_BITS   = 56;
    localparam logic [5:0]  BIT_CNT_MAX  = 6'd57;
    localparam logic [7:0]  CMD_NOTE_ON  = 8'h90;
    localparam logic [7:0]  CMD_NOTE_OFF = 8'h80;

    localparam logic [1:0]  ST_WAIT_IDLE = 2'd0;
    localparam logic [1:0]  ST_IDLE      = 2'd1;
    localparam logic [1:0]  ST_RECV      = 2'd2;
    localparam logic [1:0]  ST_CHECK     = 2'd3;

    typedef struct packed {
        logic        note_on;
        logic [7:0]  voice;
        logic [31:0] tuning;
        logic [6:0]  velocity;
    } note_msg_t;

    // Frame layout: cmd[55:48] voice[47:40] tuning[39:8] velocity[7:0]
    function automatic logic frame_ok(input logic [5:0] cnt, input logic [FRAME_BITS-1:0] sr);
        return (cnt == 6'(FRAME_BITS)) &&
               ((sr[55:48] == CMD_NOTE_ON) || (sr[55:48] == CMD_NOTE_OFF)) &&
               !sr[7];
    endfunction

    function automatic note_msg_t frame_decode(input logic [FRAME_BITS-1:0] sr);
        note_msg_t m;
        m.note_on  = (sr[55:48] == CMD_NOTE_ON);
        m.voice    = sr[47:40];
        m.tuning   = sr[39:8];
        m.velocity = sr[6:0];
        return m;
    endfunction

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchronizer for one asynchronous pin plus rise/fall edge detection.
// Latency: SYNC_STAGES cycles to level, edges flagged in the same cycle the level changes.
// Backpressure: none; free-running sampler.
module spi_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_pin,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_pin};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign o_level = sync_q[SYNC_STAGES-1];
    assign o_rise  = o_level & ~prev_q;
    assign o_fall  = ~o_level & prev_q;

endmodule

// File: rtl/spi_note_receiver.sv
// SPI mode-0 slave receiving 7-byte note messages and presenting them on registered outputs.
// Latency: flag/error one cycle after the CHECK state, which follows the synchronized CS rise.
// Backpressure: none; the SPI master must respect frame format and minimum clock ratio.
module spi_note_receiver
    import midisynth_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int CLK_RATIO_MIN = 8
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_sclk,
    input  logic        i_cs_n,
    input  logic        i_mosi,
    output logic        o_SPI_note_status,
    output logic [7:0]  o_SPI_voice_index,
    output logic [31:0] o_SPI_tuning_code,
    output logic [6:0]  o_SPI_velocity,
    output logic        o_SPI_flag,
    output logic        o_frame_error
);

    logic sclk_level, sclk_rise, sclk_fall;
    logic cs_level, cs_rise, cs_fall;
    logic mosi_level, mosi_rise, mosi_fall;

    spi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
        .i_clk(i_clk), .i_reset(i_reset), .i_pin(i_sclk),
        .o_level(sclk_level), .o_rise(sclk_rise), .o_fall(sclk_fall)
    );

    spi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
        .i_clk(i_clk), .i_reset(i_reset), .i_pin(i_cs_n),
        .o_level(cs_level), .o_rise(cs_rise), .o_fall(cs_fall)
    );

    spi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
        .i_clk(i_clk), .i_reset(i_reset), .i_pin(i_mosi),
        .o_level(mosi_level), .o_rise(mosi_rise), .o_fall(mosi_fall)
    );

    logic unused_edges;
    assign unused_edges = ^{sclk_level, sclk_fall, mosi_rise, mosi_fall};

    logic [1:0]            state;
    logic [5:0]            bit_cnt;
    logic [FRAME_BITS-1:0] shreg;
    note_msg_t             msg;

    assign msg = frame_decode(shreg);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state             <= ST_WAIT_IDLE;
            bit_cnt           <= '0;
            shreg             <= '0;
            o_SPI_note_status <= 1'b0;
            o_SPI_voice_index <= '0;
            o_SPI_tuning_code <= '0;
            o_SPI_velocity    <= '0;
            o_SPI_flag        <= 1'b0;
            o_frame_error     <= 1'b0;
        end else begin
            o_SPI_flag    <= 1'b0;
            o_frame_error <= 1'b0;
            case (state)
                // After reset, leftover bits of an interrupted frame are skipped until CS idles high
                ST_WAIT_IDLE: begin
                    if (cs_level) state <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (cs_fall) begin
                        state   <= ST_RECV;
                        bit_cnt <= '0;
                        shreg   <= '0;
                    end
                end
                ST_RECV: begin
                    if (cs_rise) begin
                        state <= ST_CHECK;
                    end else if (sclk_rise) begin
                        shreg   <= {shreg[FRAME_BITS-2:0], mosi_level};
                        bit_cnt <= (bit_cnt == BIT_CNT_MAX) ? BIT_CNT_MAX : bit_cnt + 6'd1;
                    end
                end
                ST_CHECK: begin
                    if (frame_ok(bit_cnt, shreg)) begin
                        o_SPI_note_status <= msg.note_on;
                        o_SPI_voice_index <= msg.voice;
                        o_SPI_tuning_code <= msg.tuning;
                        o_SPI_velocity    <= msg.velocity;
                        o_SPI_flag        <= 1'b1;
                    end else begin
                        o_frame_error     <= 1'b1;
                    end
                    if (cs_fall) begin
                        state   <= ST_RECV;
                        bit_cnt <= '0;
                        shreg   <= '0;
                    end else begin
                        state   <= ST_IDLE;
                    end
                end
                default: state <= ST_WAIT_IDLE;
            endcase
        end
    end

    // Cycles since the previous synchronized SCLK rise; synchronizer jitter costs up to one cycle
    localparam logic [7:0] SCLK_GAP_MIN = 8'(CLK_RATIO_MIN - 2);
    logic [7:0] sclk_gap;

    always_ff @(posedge i_clk) begin
        if (i_reset)                sclk_gap <= 8'hFF;
        else if (sclk_rise)         sclk_gap <= 8'd0;
        else if (sclk_gap != 8'hFF) sclk_gap <= sclk_gap + 8'd1;
    end

    a_sclk_ratio: assert property (@(posedge i_clk) disable iff (i_reset)
        (state == ST_RECV && sclk_rise) |-> (sclk_gap >= SCLK_GAP_MIN));

    a_strobe_excl: assert property (@(posedge i_clk) disable iff (i_reset)
        !(o_SPI_flag && o_frame_error));

endmodule

// File: tb/tb_spi_note_receiver.sv
// Scoreboard bench for spi_note_receiver: each frame pushes its expected strobe/outputs,
// a negedge monitor pops and compares whenever the DUT strobes.
module tb_spi_note_receiver;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_sclk;
    logic        i_cs_n;
    logic        i_mosi;
    logic        o_SPI_note_status;
    logic [7:0]  o_SPI_voice_index;
    logic [31:0] o_SPI_tuning_code;
    logic [6:0]  o_SPI_velocity;
    logic        o_SPI_flag;
    logic        o_frame_error;

    spi_note_receiver #(.SYNC_STAGES(2), .CLK_RATIO_MIN(8)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_sclk(i_sclk), .i_cs_n(i_cs_n), .i_mosi(i_mosi),
        .o_SPI_note_status(o_SPI_note_status), .o_SPI_voice_index(o_SPI_voice_index),
        .o_SPI_tuning_code(o_SPI_tuning_code), .o_SPI_velocity(o_SPI_velocity),
        .o_SPI_flag(o_SPI_flag), .o_frame_error(o_frame_error)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        bit          is_err;
        logic        st;
        logic [7:0]  voice;
        logic [31:0] tun;
        logic [6:0]  vel;
    } exp_t;

    exp_t        exp_q[$];
    logic        m_st;
    logic [7:0]  m_voice;
    logic [31:0] m_tun;
    logic [6:0]  m_vel;
    int          n_tests = 0;
    int          n_fail  = 0;
    bit          mon_en  = 1'b0;
    bit          prev_strobe = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: decides validity from the raw frame and tracks last valid outputs
    task automatic push_expect(input logic [63:0] data, input int nbits);
        exp_t e;
        logic [7:0] cmd;
        bit valid;
        cmd   = data[55:48];
        valid = (nbits == 56) && (cmd == 8'h90 || cmd == 8'h80) && (data[7] == 1'b0);
        if (valid) begin
            m_st    = (cmd == 8'h90);
            m_voice = data[47:40];
            m_tun   = data[39:8];
            m_vel   = data[6:0];
        end
        e.is_err = !valid;
        e.st     = m_st;
        e.voice  = m_voice;
        e.tun    = m_tun;
        e.vel    = m_vel;
        exp_q.push_back(e);
    endtask

    task automatic send_bits(input logic [63:0] data, input int nbits);
        for (int i = nbits - 1; i >= 0; i--) begin
            @(negedge i_clk);
            i_mosi = data[i];
            repeat (4) @(negedge i_clk);
            i_sclk = 1'b1;
            repeat (4) @(negedge i_clk);
            i_sclk = 1'b0;
        end
    endtask

    // CS stays high for exactly 'gap' cycles before the next frame task can lower it
    task automatic send_frame(input logic [63:0] data, input int nbits, input int gap);
        @(negedge i_clk);
        i_cs_n = 1'b0;
        repeat (3) @(negedge i_clk);
        send_bits(data, nbits);
        repeat (2) @(negedge i_clk);
        i_cs_n = 1'b1;
        repeat (gap - 1) @(negedge i_clk);
    endtask

    task automatic wait_drain();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 200) begin
            @(negedge i_clk);
            k++;
        end
        chk("drain_timeout", 64'(exp_q.size()), 0);
        repeat (5) @(negedge i_clk);
    endtask

    always @(negedge i_clk) begin
        if (mon_en && (o_SPI_flag || o_frame_error)) begin
            exp_t e;
            chk("flag_err_overlap", {63'd0, o_SPI_flag & o_frame_error}, 0);
            chk("strobe_width", {63'd0, prev_strobe}, 0);
            if (exp_q.size() == 0) begin
                chk("unexpected_strobe", {62'd0, o_SPI_flag, o_frame_error}, 0);
            end else begin
                e = exp_q.pop_front();
                chk("strobe_kind", {63'd0, o_frame_error}, {63'd0, e.is_err});
                chk("note_status", {63'd0, o_SPI_note_status}, {63'd0, e.st});
                chk("voice_index", 64'(o_SPI_voice_index), 64'(e.voice));
                chk("tuning_code", 64'(o_SPI_tuning_code), 64'(e.tun));
                chk("velocity", 64'(o_SPI_velocity), 64'(e.vel));
            end
        end
        prev_strobe = o_SPI_flag | o_frame_error;
    end

    initial begin
        i_reset = 1'b1;
        i_sclk  = 1'b0;
        i_cs_n  = 1'b1;
        i_mosi  = 1'b0;
        m_st = 1'b0; m_voice = '0; m_tun = '0; m_vel = '0;
        repeat (5) @(negedge i_clk);
        chk("rst_flag", {63'd0, o_SPI_flag}, 0);
        chk("rst_error", {63'd0, o_frame_error}, 0);
        chk("rst_status", {63'd0, o_SPI_note_status}, 0);
        chk("rst_voice", 64'(o_SPI_voice_index), 0);
        chk("rst_tuning", 64'(o_SPI_tuning_code), 0);
        chk("rst_velocity", 64'(o_SPI_velocity), 0);
        i_reset = 1'b0;
        repeat (10) @(negedge i_clk);
        mon_en = 1'b1;

        push_expect(64'h0090_0500_1000_0040, 56); send_frame(64'h0090_0500_1000_0040, 56, 10); wait_drain();
        push_expect(64'h0080_0500_1000_0000, 56); send_frame(64'h0080_0500_1000_0000, 56, 10); wait_drain();
        push_expect(64'h0000_9005_0010_0000, 48); send_frame(64'h0000_9005_0010_0000, 48, 10); wait_drain();
        push_expect(64'h9005_0010_0000_4011, 64); send_frame(64'h9005_0010_0000_4011, 64, 10); wait_drain();
        push_expect(64'h00A0_0500_1000_0040, 56); send_frame(64'h00A0_0500_1000_0040, 56, 10); wait_drain();
        push_expect(64'h0090_0500_1000_0080, 56); send_frame(64'h0090_0500_1000_0080, 56, 10); wait_drain();

        // CS low with no SCLK activity
        push_expect(64'h0, 0);
        @(negedge i_clk);
        i_cs_n = 1'b0;
        repeat (20) @(negedge i_clk);
        i_cs_n = 1'b1;
        wait_drain();

        // Reset lands mid-frame; the remainder of the frame must be ignored
        @(negedge i_clk);
        i_cs_n = 1'b0;
        repeat (3) @(negedge i_clk);
        send_bits(64'h0009_0071_2345_6722 >> 36, 20);
        i_reset = 1'b1;
        m_st = 1'b0; m_voice = '0; m_tun = '0; m_vel = '0;
        repeat (3) @(negedge i_clk);
        i_reset = 1'b0;
        send_bits(64'h0090_0712_3456_7822 & 64'h0000_000F_FFFF_FFFF, 36);
        repeat (2) @(negedge i_clk);
        i_cs_n = 1'b1;
        repeat (30) @(negedge i_clk);
        chk("midrst_voice", 64'(o_SPI_voice_index), 0);
        chk("midrst_tuning", 64'(o_SPI_tuning_code), 0);
        push_expect(64'h0090_0900_00AB_CD33, 56); send_frame(64'h0090_0900_00AB_CD33, 56, 10); wait_drain();

        // Back-to-back frames with minimum CS high time
        push_expect(64'h0090_0112_3456_7801, 56);
        push_expect(64'h0080_0287_6543_2102, 56);
        send_frame(64'h0090_0112_3456_7801, 56, 4);
        send_frame(64'h0080_0287_6543_2102, 56, 10);
        wait_drain();

        chk("hold_status", {63'd0, o_SPI_note_status}, {63'd0, m_st});
        chk("hold_voice", 64'(o_SPI_voice_index), 64'(m_voice));
        chk("hold_tuning", 64'(o_SPI_tuning_code), 64'(m_tun));
        chk("hold_velocity", 64'(o_SPI_velocity), 64'(m_vel));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_note_receiver.md
SPI_NOTE_RECEIVER -- requirements
Module: spi_note_receiver

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of flip-flops in each pin synchronizer (minimum 2).
REQ-002 SHALL have parameter CLK_RATIO_MIN, default 8, minimum i_clk/SCLK frequency ratio the design guarantees; used only for documentation and assertions.
REQ-003 SHALL have port i_clk  input  1  system clock; the only clock in the block.
REQ-004 SHALL have port i_reset  input  1  reset, synchronous to i_clk and active-high.
REQ-005 SHALL have port i_sclk  input  1  SPI clock, asynchronous to i_clk, mode 0.
REQ-006 SHALL have port i_cs_n  input  1  SPI chip select, active-low, asynchronous.
REQ-007 SHALL have port i_mosi  input  1  SPI data, MSB first, asynchronous.
REQ-008 SHALL have port o_SPI_note_status  output  1  1 = note on, 0 = note off.
REQ-009 SHALL have port o_SPI_voice_index  output  8  target voice.
REQ-010 SHALL have port o_SPI_tuning_code  output  32  DDS phase increment.
REQ-011 SHALL have port o_SPI_velocity  output  7  note velocity.
REQ-012 SHALL have port o_SPI_flag  output  1  one-cycle strobe: a new valid message is on the o_SPI_* outputs.
REQ-013 SHALL have port o_frame_error  output  1  one-cycle strobe: the frame was discarded.

Function
REQ-014 SHALL pass i_sclk, i_cs_n and i_mosi through SYNC_STAGES flip-flops each, then detect SCLK rising and CS rising/falling edges on the synchronized signals.
REQ-015 SHALL define a frame as 56 bits (7 bytes) between CS falling and CS rising: byte0 command (0x90 note on, 0x80 note off), byte1 voice index, bytes2-5 tuning code (MSB first), byte6 velocity (bit7 = 0).
REQ-016 SHALL sample synchronized MOSI on each synchronized SCLK rising edge into a 56-bit shift register, with a 6-bit bit counter that saturates at 57.
REQ-017 SHALL implement the states WAIT_IDLE, IDLE, RECV and CHECK.
REQ-018 WAIT_IDLE: go to IDLE when synchronized CS is high.
REQ-019 IDLE: go to RECV on CS falling, and clear the counter and shift register.
REQ-020 RECV: shift on SCLK rising edges; go to CHECK on CS rising.
REQ-021 CHECK: lasts exactly one cycle, then goes to IDLE.
REQ-022 In CHECK, the frame SHALL be valid only if: bit count = 56, command is 0x90 or 0x80, and velocity bit7 = 0.
REQ-023 On a valid frame, SHALL update all o_SPI_* data outputs and assert o_SPI_flag in the same cycle, the cycle after CHECK (registered), for exactly one cycle.
REQ-024 On an invalid frame (short, long, bad command, or velocity bit7 set), SHALL assert o_frame_error for one cycle at the same timing, leave the data outputs unchanged, and leave o_SPI_flag low.
REQ-025 Data outputs SHALL hold their last valid values between flags.
REQ-026 o_SPI_flag and o_frame_error SHALL never be high in the same cycle.
REQ-027 An SCLK edge detected in the same cycle as CS rising SHALL be ignored.
REQ-028 A CS falling edge detected while in CHECK SHALL be honoured: the next state is RECV with the counter cleared.
REQ-029 Back-to-back frames with a CS high time of at least SYNC_STAGES+2 i_clk cycles SHALL each produce their own flag.
REQ-030 A CS low period with zero SCLK edges SHALL produce o_frame_error.

Reset
REQ-031 While i_reset is high, SHALL clear all outputs to 0, clear the synchronizers, shift register and counter, and set the state to WAIT_IDLE.
REQ-032 Reset in mid-frame SHALL discard the partial frame with no flag and no error; the remaining bits of that frame SHALL be ignored until CS has been seen high.

Structure
REQ-033 SHALL take the frame length (56), the command codes (0x90 and 0x80) and the state encoding from the shared package midisynth_pkg.
REQ-034 SHALL instantiate the sub-module spi_sync (a SYNC_STAGES synchronizer plus rise/fall edge detector) once per pin.
REQ-035 SHALL be sized at 150-250 lines of RTL, with no memories.

Verification
REQ-036 Note-on 90 05 00 10 00 00 40 at i_clk/SCLK = 8 -> exactly one o_SPI_flag; outputs status=1, voice=0x05, tuning=0x00100000, velocity=0x40.
REQ-037 Note-off 80 05 00 10 00 00 00, sent after REQ-036 -> flag; status=0, voice=0x05; tuning stays 0x00100000 as transmitted.
REQ-038 Short frame (48 bits), long frame (64 bits), command 0xA0, velocity byte 0x80 -> o_frame_error once each; no flag; outputs keep previous values.
REQ-039 Reset asserted after 20 bits with CS held low, then 36 more bits and CS rising -> no flag and no error; the next valid frame -> flag with correct data.
REQ-040 Two valid frames with CS high time of 4 i_clk cycles -> two flags, the second carrying frame 2 data; at no point are flag and error high together.
